// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic datapath blocks (divider FSM states,
// default operand width, iteration counter sizing).
package arith_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } div_state_e;

  // Default operand/result width.
  localparam int DEFAULT_WIDTH = 4;

  // Iteration counter width: one spare bit above clog2 so WIDTH-1 always fits.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   i_r,
  input  logic             i_q_msb,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH:0]   o_r,
  output logic             o_q_bit
);

  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_trial;

  // Trial subtraction; a set sign bit means the divisor did not fit.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
    w_shifted = {i_r, i_q_msb};
    w_trial   = w_shifted - {2'b00, i_d};
    o_q_bit   = ~w_trial[WIDTH+1];
    o_r       = w_trial[WIDTH+1] ? w_shifted[WIDTH:0] : w_trial[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// One quotient bit per clock; results are registered and held until the next
// accepted operation.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_e        r_state;
  logic [WIDTH:0]    r_rem;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_div;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [WIDTH-1:0]  r_quotient;
  logic [WIDTH-1:0]  r_remainder;
  logic              r_dbz;

  logic [WIDTH:0]    w_rem_next;
  logic              w_q_bit;
  logic [WIDTH-1:0]  w_quo_next;
  logic              w_accept;

  // A new operation is taken whenever no division is in flight.
  assign w_accept   = start && ((r_state == IDLE) || (r_state == FINISH));
  assign w_quo_next = {r_quo[WIDTH-2:0], w_q_bit};

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r     (r_rem),
    .i_q_msb (r_quo[WIDTH-1]),
    .i_d     (r_div),
    .o_r     (w_rem_next),
    .o_q_bit (w_q_bit)
  );

  // Control FSM, working registers and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: reset is synchronous and clears every register, working state included, so an aborted division leaves nothing behind.
      r_state     <= IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      r_done <= 1'b0;
      case (r_state)
        IDLE, FINISH: begin
          if (w_accept) begin
            r_quo <= dividend;
            r_div <= divisor;
            r_rem <= '0;
            r_cnt <= '0;
            if (divisor == '0) begin
              // Divide-by-zero short-cuts straight to the result cycle.
              r_state     <= FINISH;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_ITER) begin
            r_state     <= FINISH;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_quo_next;
            r_remainder <= w_rem_next[WIDTH-1:0];
            r_dbz       <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: WIDTH=4 and WIDTH=8 instances compared
// every cycle against a cycle-count/arithmetic reference model, plus directed
// literal expectations.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, busy4, done4, dbz4;
  logic [3:0] a4, b4, q4, r4;
  logic       start8, busy8, done8, dbz8;
  logic [7:0] a8, b8, q8, r8;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  // Reference model: expected outputs plus cycles left until the result.
  typedef struct {
    int busy; int done; int q; int r; int dbz;
    int rem; int pq; int pr; int a; int b;
  } model_t;

  model_t m4, m8;

  function automatic model_t model_step(input model_t m, input logic rst, input logic st,
                                        input int a, input int b, input int w);
    model_t n = m;
    n.done = 0;
    if (!rst) begin
      n = '{default: 0};
      return n;
    end
    if (st && m.busy == 0) begin
      n.a = a;
      n.b = b;
      if (b == 0) begin
        n.done = 1; n.busy = 0; n.rem = 0;
        n.q = (1 << w) - 1; n.r = a; n.dbz = 1;
      end else begin
        n.busy = 1; n.rem = w;
        n.pq = a / b; n.pr = a % b;
      end
    end else if (m.rem > 0) begin
      n.rem = m.rem - 1;
      if (m.rem == 1) begin
        n.busy = 0; n.done = 1;
        n.q = m.pq; n.r = m.pr; n.dbz = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m4 <= model_step(m4, rst_n, start4, int'(a4), int'(b4), 4);
    m8 <= model_step(m8, rst_n, start8, int'(a8), int'(b8), 8);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy4", 32'(busy4), 32'(m4.busy));
      check("done4", 32'(done4), 32'(m4.done));
      check("quot4", 32'(q4),    32'(m4.q));
      check("rem4",  32'(r4),    32'(m4.r));
      check("dbz4",  32'(dbz4),  32'(m4.dbz));
      check("busy8", 32'(busy8), 32'(m8.busy));
      check("done8", 32'(done8), 32'(m8.done));
      check("quot8", 32'(q8),    32'(m8.q));
      check("rem8",  32'(r8),    32'(m8.r));
      check("dbz8",  32'(dbz8),  32'(m8.dbz));
      if (done8 === 1'b1 && m8.b != 0) begin
        check("inv8_eq", 32'(q8) * 32'(m8.b) + 32'(r8), 32'(m8.a));
        check("inv8_lt", {31'b0, (32'(r8) < 32'(m8.b))}, 32'd1);
      end
    end
  end

  // Issue one operation from a negedge; returns cycles to done and busy cycles seen.
  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int nbusy);
    start4 = 1'b1; a4 = a; b4 = b; lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      start4 = 1'b0;
      lat++;
      if (busy4) nbusy++;
    end while (!done4 && lat < 40);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat, output int nbusy);
    start8 = 1'b1; a8 = a; b8 = b; lat = 0; nbusy = 0;
    do begin
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      if (busy8) nbusy++;
    end while (!done8 && lat < 40);
  endtask

  initial begin
    int lat, nb, n, ndone;
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    @(posedge clk);
    #1 cmp_en = 1'b1;
    @(negedge clk);
    check("reset_busy4", 32'(busy4), 0);
    check("reset_quot4", 32'(q4), 0);
    check("reset_dbz8",  32'(dbz8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 13/3
    run4(4'd13, 4'd3, lat, nb);
    check("t1_latency", lat, 5);
    check("t1_busy_cycles", nb, 4);
    check("t1_quot", 32'(q4), 4);
    check("t1_rem", 32'(r4), 1);
    check("t1_dbz", 32'(dbz4), 0);

    // Back-to-back on each done cycle
    run4(4'd15, 4'd1, lat, nb);
    check("b2b1_latency", lat, 5);
    check("b2b1_quot", 32'(q4), 15);
    check("b2b1_rem", 32'(r4), 0);
    run4(4'd0, 4'd5, lat, nb);
    check("b2b2_latency", lat, 5);
    check("b2b2_quot", 32'(q4), 0);
    check("b2b2_rem", 32'(r4), 0);
    run4(4'd3, 4'd9, lat, nb);
    check("b2b3_latency", lat, 5);
    check("b2b3_quot", 32'(q4), 0);
    check("b2b3_rem", 32'(r4), 3);

    // Divide by zero, then a normal division
    @(negedge clk);
    run4(4'd7, 4'd0, lat, nb);
    check("dz_latency", lat, 1);
    check("dz_busy_cycles", nb, 0);
    check("dz_quot", 32'(q4), 15);
    check("dz_rem", 32'(r4), 7);
    check("dz_flag", 32'(dbz4), 1);
    @(negedge clk);
    run4(4'd8, 4'd2, lat, nb);
    check("after_dz_quot", 32'(q4), 4);
    check("after_dz_rem", 32'(r4), 0);
    check("after_dz_flag", 32'(dbz4), 0);

    // Start while busy is ignored; operand changes while busy have no effect
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd14; b4 = 4'd4;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clk);
    start4 = 1'b0; a4 = 4'd5; b4 = 4'd1;
    n = 0;
    while (!done4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ign_latency", n, 2);
    check("ign_quot", 32'(q4), 3);
    check("ign_rem", 32'(r4), 2);

    // Reset after two CALC cycles aborts the division
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd11; b4 = 4'd2;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", 32'(busy4), 0);
    check("abort_done", 32'(done4), 0);
    check("abort_quot", 32'(q4), 0);
    check("abort_rem", 32'(r4), 0);
    check("abort_dbz", 32'(dbz4), 0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run4(4'd11, 4'd2, lat, nb);
    check("rerun_latency", lat, 5);
    check("rerun_quot", 32'(q4), 5);
    check("rerun_rem", 32'(r4), 1);

    // WIDTH=8 directed
    @(negedge clk);
    run8(8'd200, 8'd7, lat, nb);
    check("w8_latency", lat, 9);
    check("w8_busy_cycles", nb, 8);
    check("w8_quot", 32'(q8), 28);
    check("w8_rem", 32'(r8), 4);

    // WIDTH=8 random sweep with random start pulses (many land while busy)
    ndone = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done8) ndone++;
      start8 = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       a8 = 8'd0;
        1:       a8 = 8'hFF;
        default: a8 = 8'($urandom);
      endcase
      case ($urandom_range(0, 15))
        0:       b8 = 8'd0;
        1:       b8 = 8'd1;
        2:       b8 = 8'hFF;
        3:       b8 = a8;
        default: b8 = 8'($urandom);
      endcase
    end
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("rand_activity", {31'b0, (ndone > 100)}, 32'd1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
